// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the intersection phase sequencer and its surroundings:
// animation clock, switch request, collision flag in; approach colours and status out.
interface traffic_light_ctrl_if;
   localparam int unsigned PHASE_W = 3;
   localparam int unsigned TICK_W  = 10;

   logic               animateClk;
   logic               switch_req;
   logic               game_over;
   logic               traffic0_color;
   logic               traffic1_color;
   logic               traffic2_color;
   logic               traffic3_color;
   logic [PHASE_W-1:0] phase;
   logic [TICK_W-1:0]  ticks_left;

   modport master (
      output animateClk, switch_req, game_over,
      input  traffic0_color, traffic1_color, traffic2_color, traffic3_color,
             phase, ticks_left
   );

   modport slave (
      input  animateClk, switch_req, game_over,
      output traffic0_color, traffic1_color, traffic2_color, traffic3_color,
             phase, ticks_left
   );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Intersection phase sequencer: NS green / clear / EW green / clear, timed in
// animation ticks, with early-switch shortening and a latched game-over halt.
module traffic_light_ctrl #(
   parameter int unsigned GREEN_TICKS = 240,
   parameter int unsigned CLEAR_TICKS = 60,
   parameter int unsigned MIN_GREEN   = 30
) (
   input  logic                 dclk,
   input  logic                 clr,
   traffic_light_ctrl_if.slave  bus
);

   localparam int unsigned TW = 10;
   localparam logic [TW-1:0] GREEN_LD = TW'(GREEN_TICKS);
   localparam logic [TW-1:0] CLEAR_LD = TW'(CLEAR_TICKS);
   localparam logic [TW-1:0] MIN_LD   = TW'(MIN_GREEN);
   localparam logic [TW-1:0] ONE      = TW'(1);

   typedef enum logic [2:0] {
      INIT_RED = 3'd0,
      NS_GREEN = 3'd1,
      NS_CLEAR = 3'd2,
      EW_GREEN = 3'd3,
      EW_CLEAR = 3'd4,
      HALT     = 3'd5
   } state_t;

   state_t          state;
   logic [TW-1:0]   ticks_left;
   logic            ns_go;
   logic            ew_go;
   logic            s1;
   logic            s2;
   logic            s3;
   logic            tick_c;
   logic            green_c;

   // Successor in the repeating phase cycle; HALT only leaves through clr.
   function automatic state_t next_of(input state_t s);
      case (s)
         INIT_RED: next_of = NS_GREEN;
         NS_GREEN: next_of = NS_CLEAR;
         NS_CLEAR: next_of = EW_GREEN;
         EW_GREEN: next_of = EW_CLEAR;
         EW_CLEAR: next_of = NS_GREEN;
         default:  next_of = HALT;
      endcase
   endfunction

   function automatic logic [TW-1:0] load_of(input state_t s);
      case (s)
         NS_GREEN, EW_GREEN: load_of = GREEN_LD;
         HALT:               load_of = '0;
         default:            load_of = CLEAR_LD;
      endcase
   endfunction

   // One dclk-wide pulse per rising edge of the synchronized animation clock.
   assign tick_c  = s2 & ~s3;
   assign green_c = (state == NS_GREEN) || (state == EW_GREEN);

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
         state      <= INIT_RED;
         ticks_left <= CLEAR_LD;
         ns_go      <= 1'b0;
         ew_go      <= 1'b0;
      end else begin
         s1 <= bus.animateClk;
         s2 <= s1;
         s3 <= s2;
         if (bus.game_over) begin
            // Collision wins over any tick or phase change in the same cycle.
            state      <= HALT;
            ticks_left <= '0;
            ns_go      <= 1'b0;
            ew_go      <= 1'b0;
         end else if (tick_c && state != HALT) begin
            if (ticks_left == ONE) begin
               state      <= next_of(state);
               ticks_left <= load_of(next_of(state));
               ns_go      <= (next_of(state) == NS_GREEN);
               ew_go      <= (next_of(state) == EW_GREEN);
            end else if (green_c && bus.switch_req && ticks_left > MIN_LD) begin
               ticks_left <= MIN_LD;
            end else begin
               ticks_left <= ticks_left - ONE;
            end
         end
      end
   end

   assign bus.phase          = state;
   assign bus.ticks_left     = ticks_left;
   assign bus.traffic0_color = ns_go;
   assign bus.traffic2_color = ns_go;
   assign bus.traffic1_color = ew_go;
   assign bus.traffic3_color = ew_go;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with GREEN_TICKS=4, CLEAR_TICKS=2, MIN_GREEN=1.
module tb_traffic_light_ctrl;

   logic dclk = 1'b0;
   logic clr  = 1'b1;
   bit   run  = 1'b1;
   int   total = 0;
   int   bad   = 0;

   traffic_light_ctrl_if bus ();

   traffic_light_ctrl #(
      .GREEN_TICKS(4),
      .CLEAR_TICKS(2),
      .MIN_GREEN  (1)
   ) dut (
      .dclk (dclk),
      .clr  (clr),
      .bus  (bus.slave)
   );

   always begin
      #5;
      if (run) dclk = ~dclk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] colors();
      return {bus.traffic0_color, bus.traffic1_color, bus.traffic2_color, bus.traffic3_color};
   endfunction

   function automatic logic [3:0] exp_colors(input int ph);
      if (ph == 1) return 4'b1010;
      if (ph == 3) return 4'b0101;
      return 4'b0000;
   endfunction

   // One animation tick; update is visible after the 3rd negedge, task returns after 6.
   task automatic tick();
      bus.animateClk = 1'b1;
      repeat (3) @(negedge dclk);
      bus.animateClk = 1'b0;
      repeat (3) @(negedge dclk);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      #1;
      check("clr_async_phase", 32'(bus.phase), 0);
      @(negedge dclk);
      clr = 1'b0;
      @(negedge dclk);
   endtask

   // NS and EW must never be green together.
   always @(negedge dclk) begin
      if (!clr)
         check("mutex", 32'((bus.traffic0_color | bus.traffic2_color) &
                            (bus.traffic1_color | bus.traffic3_color)), 0);
   end

   int exp_ph [24] = '{0,1,1,1,1,2,2,3,3,3,3,4,4,1,1,1,1,2,2,3,3,3,3,4};
   int exp_tl [24] = '{1,4,3,2,1,2,1,4,3,2,1,2,1,4,3,2,1,2,1,4,3,2,1,2};

   initial begin
      bus.animateClk = 1'b0;
      bus.switch_req = 1'b0;
      bus.game_over  = 1'b0;

      // Reset state
      repeat (3) @(negedge dclk);
      check("rst_phase", 32'(bus.phase), 0);
      check("rst_ticks", 32'(bus.ticks_left), 2);
      check("rst_colors", 32'(colors()), 0);
      clr = 1'b0;
      @(negedge dclk);

      // Full cycle
      for (int i = 0; i < 24; i++) begin
         tick();
         check($sformatf("cyc%0d_phase", i), 32'(bus.phase), 32'(exp_ph[i]));
         check($sformatf("cyc%0d_ticks", i), 32'(bus.ticks_left), 32'(exp_tl[i]));
         check($sformatf("cyc%0d_colors", i), 32'(colors()), 32'(exp_colors(exp_ph[i])));
      end

      // Asynchronous reset with dclk stopped
      @(negedge dclk);
      run = 1'b0;
      #20;
      clr = 1'b1;
      #1;
      check("stop_rst_phase", 32'(bus.phase), 0);
      check("stop_rst_ticks", 32'(bus.ticks_left), 2);
      check("stop_rst_colors", 32'(colors()), 0);
      #4;
      clr = 1'b0;
      #20;
      run = 1'b1;
      @(negedge dclk);

      // Switch request shortens NS green, then transitions normally at 1
      tick();
      tick();
      check("sw_pre_phase", 32'(bus.phase), 1);
      check("sw_pre_ticks", 32'(bus.ticks_left), 4);
      bus.switch_req = 1'b1;
      tick();
      check("sw_short_ticks", 32'(bus.ticks_left), 1);
      check("sw_short_phase", 32'(bus.phase), 1);
      tick();
      check("sw_at1_phase", 32'(bus.phase), 2);
      check("sw_at1_ticks", 32'(bus.ticks_left), 2);
      bus.switch_req = 1'b0;
      tick();
      tick();
      check("ew_phase", 32'(bus.phase), 3);
      check("ew_ticks", 32'(bus.ticks_left), 4);
      tick();
      check("ew_ticks3", 32'(bus.ticks_left), 3);

      // Game over during EW green
      bus.game_over = 1'b1;
      @(negedge dclk);
      bus.game_over = 1'b0;
      check("go_phase", 32'(bus.phase), 5);
      check("go_ticks", 32'(bus.ticks_left), 0);
      check("go_colors", 32'(colors()), 0);
      for (int i = 0; i < 10; i++) begin
         bus.switch_req = 1'(i % 2);
         tick();
         check($sformatf("halt%0d_phase", i), 32'(bus.phase), 5);
         check($sformatf("halt%0d_ticks", i), 32'(bus.ticks_left), 0);
      end
      bus.switch_req = 1'b0;
      pulse_clr();
      check("go_clr_ticks", 32'(bus.ticks_left), 2);
      check("go_clr_colors", 32'(colors()), 0);

      // Game over coinciding with a transition tick
      tick();
      check("sim_pre_ticks", 32'(bus.ticks_left), 1);
      bus.animateClk = 1'b1;
      @(negedge dclk);
      @(negedge dclk);
      bus.game_over = 1'b1;
      @(negedge dclk);
      bus.game_over = 1'b0;
      check("sim_phase", 32'(bus.phase), 5);
      check("sim_ticks", 32'(bus.ticks_left), 0);
      bus.animateClk = 1'b0;
      repeat (3) @(negedge dclk);
      pulse_clr();

      // Long high level yields a single tick
      bus.animateClk = 1'b1;
      repeat (100) @(negedge dclk);
      check("hold_ticks", 32'(bus.ticks_left), 1);
      check("hold_phase", 32'(bus.phase), 0);
      bus.animateClk = 1'b0;
      repeat (5) @(negedge dclk);
      check("hold_low_ticks", 32'(bus.ticks_left), 1);

      // One-cycle pulse: update lands on the third edge
      bus.animateClk = 1'b1;
      @(negedge dclk);
      bus.animateClk = 1'b0;
      check("pulse_e1_phase", 32'(bus.phase), 0);
      @(negedge dclk);
      check("pulse_e2_ticks", 32'(bus.ticks_left), 1);
      @(negedge dclk);
      check("pulse_e3_phase", 32'(bus.phase), 1);
      check("pulse_e3_ticks", 32'(bus.ticks_left), 4);
      check("pulse_e3_colors", 32'(colors()), 32'(4'b1010));
      repeat (5) @(negedge dclk);
      check("pulse_once_ticks", 32'(bus.ticks_left), 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
